// File: rtl/bcd_to_binary_pkg.sv
// Shared constants, state encoding and digit helpers for the sequential
// packed-BCD to binary converter.
package bcd_to_binary_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;
  localparam int BCD_W      = 4;
  localparam int OUT_W      = 16;
  localparam int CNT_W_DEF  = $clog2(BIN_W_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A packed-BCD digit is only legal in the range 0..9.
  function automatic logic digit_invalid(input logic [BCD_W-1:0] digit);
    return (digit > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: a post-shift field of 8 or
// more had a ten-weight bit shifted into it and must drop by 3.
module bcd_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Subtract-3 correction; a legal field never exceeds 12, so no underflow.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) begin
      digit_o = digit_i - 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: reverse double-dabble, one
// shift/correct iteration per cycle, start/valid handshake.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BCD_W*DIGITS-1:0]   bcd_in,
  output logic [OUT_W-1:0]          bin_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      err
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int WORK_W  = BCD_TOT + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);

  state_e             state_q;
  logic [WORK_W-1:0]  work_q;
  logic [WORK_W-1:0]  work_d;
  logic [WORK_W-1:0]  shifted_s;
  logic [BCD_TOT-1:0] adjusted_s;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_flag_q;
  logic               bad_digit_s;
  logic [OUT_W-1:0]   bin_ext_s;
  logic [OUT_W-1:0]   bin_q;
  logic               valid_q;
  logic               busy_q;
  logic               err_q;

  assign shifted_s = work_q >> 1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_i (shifted_s[BIN_W + BCD_W*g +: BCD_W]),
        .digit_o (adjusted_s[BCD_W*g +: BCD_W])
      );
    end
  endgenerate

  assign work_d = {adjusted_s, shifted_s[BIN_W-1:0]};

  // Flag any out-of-range digit on the input being offered for capture.
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_digit_s = bad_digit_s | digit_invalid(bcd_in[i*BCD_W +: BCD_W]);
    end
  end

  // Zero-extend the binary part of the working register to the output width.
  always_comb begin
    bin_ext_s = '0;
    bin_ext_s[BIN_W-1:0] = work_q[BIN_W-1:0];
  end

  // Conversion FSM with working register, iteration counter and output regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q     <= {bcd_in, {BIN_W{1'b0}}};
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            err_flag_q <= bad_digit_s;
            state_q    <= bad_digit_s ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          bin_q   <= err_flag_q ? {OUT_W{1'b0}} : bin_ext_s;
          err_q   <= err_flag_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
